// File: rtl/week_5_priority_encoder_seq_if.sv
// Request/grant bundle between raw request lines, the priority encoder and its consumer.
// The master drives requests and acks; the slave (the encoder) drives the grant outputs.
interface week_5_priority_encoder_seq_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req_in;
    logic             ack;
    logic             out_valid;
    logic [W-1:0]     out_idx;
    logic [N-1:0]     out_onehot;
    logic [N-1:0]     pending;
    logic             multi;
    logic [CNT_W-1:0] grant_count;

    modport master (
        output req_in, ack,
        input  out_valid, out_idx, out_onehot, pending, multi, grant_count
    );

    modport slave (
        input  req_in, ack,
        output out_valid, out_idx, out_onehot, pending, multi, grant_count
    );
endinterface

// File: rtl/week_5_priority_encoder_seq.sv
// Registered N-to-log2(N) priority encoder with sticky request capture,
// a valid/ack grant handshake and a wrapping count of completed grants.
module week_5_priority_encoder_seq #(
    parameter int N         = 8,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    week_5_priority_encoder_seq_if.slave bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [W-1:0]     idx_q, idx_d;
    logic [N-1:0]     oh_q, oh_d;
    logic             vld_q, vld_d;
    logic             multi_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hs;
    logic [N-1:0]     rem;

    function automatic logic [W-1:0] enc(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        // The last hit in scan order wins, so scan away from the preferred end.
        for (int i = 0; i < N; i++) begin
            if (LSB_FIRST != 0) begin
                if (v[N-1-i]) r = W'(N-1-i);
            end else begin
                if (v[i]) r = W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [W-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    assign hs  = vld_q & bus.ack;
    // Same-cycle re-request of the acked bit must survive, so set is applied after clear.
    assign pend_d = (pend_q & ~(hs ? oh_q : '0)) | bus.req_in;
    // Remaining work deliberately excludes this cycle's req_in.
    assign rem    = pend_q & ~oh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            vld_q   <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
            multi_q <= (pend_d & (pend_d - 1'b1)) != '0;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q != '0)      state_d = PRESENT;
            PRESENT: if (hs && rem == '0)   state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        oh_d  = oh_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    idx_d = enc(pend_q);
                    oh_d  = onehot(enc(pend_q));
                    vld_d = 1'b1;
                end else begin
                    idx_d = '0;
                    oh_d  = '0;
                    vld_d = 1'b0;
                end
            end
            PRESENT: begin
                if (hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (rem != '0) begin
                        idx_d = enc(rem);
                        oh_d  = onehot(enc(rem));
                        vld_d = 1'b1;
                    end else begin
                        idx_d = '0;
                        oh_d  = '0;
                        vld_d = 1'b0;
                    end
                end
            end
            default: begin
                idx_d = '0;
                oh_d  = '0;
                vld_d = 1'b0;
            end
        endcase
    end

    assign bus.out_valid   = vld_q;
    assign bus.out_idx     = idx_q;
    assign bus.out_onehot  = oh_q;
    assign bus.pending     = pend_q;
    assign bus.multi       = multi_q;
    assign bus.grant_count = cnt_q;
endmodule

// File: tb/tb_week_5_priority_encoder_seq.sv
// Bench for the sequential priority encoder: three instances (LSB-first, MSB-first,
// 2-bit counter) share stimulus; grants are checked from expectation queues.
module tb_week_5_priority_encoder_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    int         checks = 0;
    int         errors = 0;
    int         q_lsb[$];
    int         q_msb[$];

    always #5 clk = ~clk;

    week_5_priority_encoder_seq_if #(.N(4), .CNT_W(8)) bl();
    week_5_priority_encoder_seq_if #(.N(4), .CNT_W(8)) bm();
    week_5_priority_encoder_seq_if #(.N(4), .CNT_W(2)) bc();

    assign bl.req_in = req;
    assign bl.ack    = ack;
    assign bm.req_in = req;
    assign bm.ack    = ack;
    assign bc.req_in = req;
    assign bc.ack    = ack;

    week_5_priority_encoder_seq #(.N(4), .LSB_FIRST(1), .CNT_W(8)) dut_lsb (.clk(clk), .rst(rst), .bus(bl.slave));
    week_5_priority_encoder_seq #(.N(4), .LSB_FIRST(0), .CNT_W(8)) dut_msb (.clk(clk), .rst(rst), .bus(bm.slave));
    week_5_priority_encoder_seq #(.N(4), .LSB_FIRST(1), .CNT_W(2)) dut_c2  (.clk(clk), .rst(rst), .bus(bc.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a handshake is about to happen, so the presented grant is popped.
    always @(negedge clk) begin
        if (!rst && ack && bl.out_valid) begin
            if (q_lsb.size() == 0) begin
                checks++; errors++;
                $display("FAIL lsb_unexpected_grant: got idx %0d expected none", bl.out_idx);
            end else begin
                int e;
                logic [3:0] eoh;
                e = q_lsb.pop_front();
                eoh = 4'b0001 << e;
                chk("lsb_grant_idx", 32'(bl.out_idx), 32'(e));
                chk("lsb_grant_onehot", 32'(bl.out_onehot), 32'(eoh));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ack && bm.out_valid) begin
            if (q_msb.size() == 0) begin
                checks++; errors++;
                $display("FAIL msb_unexpected_grant: got idx %0d expected none", bm.out_idx);
            end else begin
                int e;
                e = q_msb.pop_front();
                chk("msb_grant_idx", 32'(bm.out_idx), 32'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'b1111; ack = 1'b1;
        step(); step();
        chk("reset_valid", 32'(bl.out_valid), 0);
        chk("reset_pending", 32'(bl.pending), 0);
        chk("reset_count", 32'(bl.grant_count), 0);
        rst = 1'b0; req = '0; ack = 1'b0;
        step();
        chk("idle_valid", 32'(bl.out_valid), 0);

        // One-hot sweep: valid two edges after each pulse.
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001 << i;
            q_lsb.push_back(i); q_msb.push_back(i);
            step();
            req = '0;
            chk("sweep_pending", 32'(bl.pending), 32'(4'b0001 << i));
            chk("sweep_valid_early", 32'(bl.out_valid), 0);
            step();
            chk("sweep_valid", 32'(bl.out_valid), 1);
            chk("sweep_multi", 32'(bl.multi), 0);
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("sweep_valid_after_ack", 32'(bl.out_valid), 0);
        end
        chk("sweep_count", 32'(bl.grant_count), 4);

        // Two simultaneous requests, served back to back in priority order.
        req = 4'b1010;
        q_lsb.push_back(1); q_lsb.push_back(3);
        q_msb.push_back(3); q_msb.push_back(1);
        step();
        req = '0;
        chk("multi_pending", 32'(bl.pending), 32'hA);
        chk("multi_flag", 32'(bl.multi), 1);
        step();
        chk("multi_first_idx", 32'(bl.out_idx), 1);
        chk("multi_first_idx_msb", 32'(bm.out_idx), 3);
        chk("multi_first_onehot", 32'(bl.out_onehot), 32'h2);
        ack = 1'b1;
        step();
        chk("b2b_valid", 32'(bl.out_valid), 1);
        chk("b2b_idx", 32'(bl.out_idx), 3);
        chk("b2b_idx_msb", 32'(bm.out_idx), 1);
        chk("b2b_multi", 32'(bl.multi), 0);
        chk("b2b_pending", 32'(bl.pending), 32'h8);
        step();
        ack = 1'b0;
        chk("multi_done_valid", 32'(bl.out_valid), 0);
        chk("multi_done_count", 32'(bl.grant_count), 6);

        // No preemption by a higher-priority arrival.
        req = 4'b0100;
        q_lsb.push_back(2); q_msb.push_back(2);
        step();
        req = '0;
        step();
        req = 4'b0001;
        step();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            chk("nopreempt_idx", 32'(bl.out_idx), 2);
            chk("nopreempt_valid", 32'(bl.out_valid), 1);
            step();
        end
        q_lsb.push_back(0); q_msb.push_back(0);
        ack = 1'b1;
        step();
        chk("nopreempt_next_idx", 32'(bl.out_idx), 0);
        chk("nopreempt_next_valid", 32'(bl.out_valid), 1);
        step();
        ack = 1'b0;
        chk("nopreempt_done_valid", 32'(bl.out_valid), 0);

        // Re-request of the acked bit in the same cycle: set wins.
        req = 4'b0010;
        q_lsb.push_back(1); q_msb.push_back(1);
        step();
        req = '0;
        step();
        ack = 1'b1; req = 4'b0010;
        q_lsb.push_back(1); q_msb.push_back(1);
        step();
        ack = 1'b0; req = '0;
        chk("rereq_idle_valid", 32'(bl.out_valid), 0);
        chk("rereq_pending", 32'(bl.pending), 32'h2);
        chk("rereq_count", 32'(bl.grant_count), 9);
        step();
        chk("rereq_valid", 32'(bl.out_valid), 1);
        chk("rereq_idx", 32'(bl.out_idx), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rereq_done_valid", 32'(bl.out_valid), 0);
        chk("rereq_done_count", 32'(bl.grant_count), 10);

        // Reset overrides an in-flight grant and ignores req_in.
        req = 4'b1010;
        step();
        req = '0;
        step();
        chk("prereset_valid", 32'(bl.out_valid), 1);
        rst = 1'b1; req = 4'b1111;
        step();
        rst = 1'b0; req = '0;
        chk("rst_valid", 32'(bl.out_valid), 0);
        chk("rst_idx", 32'(bl.out_idx), 0);
        chk("rst_onehot", 32'(bl.out_onehot), 0);
        chk("rst_pending", 32'(bl.pending), 0);
        chk("rst_multi", 32'(bl.multi), 0);
        chk("rst_count", 32'(bl.grant_count), 0);
        chk("rst_count_c2", 32'(bc.grant_count), 0);
        step(); step();
        chk("postrst_valid", 32'(bl.out_valid), 0);
        chk("postrst_pending", 32'(bl.pending), 0);

        // Counter wrap with CNT_W=2.
        for (int i = 0; i < 5; i++) begin
            req = 4'b0001;
            q_lsb.push_back(0); q_msb.push_back(0);
            step();
            req = '0;
            step();
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("wrap_count_c2", 32'(bc.grant_count), 1);
        chk("wrap_count", 32'(bl.grant_count), 5);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("stray_ack_count_c2", 32'(bc.grant_count), 1);
        chk("stray_ack_count", 32'(bl.grant_count), 5);
        chk("stray_ack_valid", 32'(bl.out_valid), 0);

        chk("lsb_queue_drained", 32'(q_lsb.size()), 0);
        chk("msb_queue_drained", 32'(q_msb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
